datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Clock  input  1  Sole clock; all state changes on its rising edge.
REQ-002 Reset  input  1  Synchronous, active-high reset; sampled on the rising edge of Clock.
REQ-003 Instr  input  32  Instruction word; valid only while Instr_Valid=1.
REQ-004 Instr_Valid  input  1  Instruction offered by the upstream source.
REQ-005 Instr_Ready  output  1  Controller accepts Instr on this edge when Instr_Valid=1.
REQ-006 Zero  input  1  ALU zero flag from the datapath.
REQ-007 Read_Addr_1, Read_Addr_2  output  5 each  Register file read addresses.
REQ-008 Write_Addr  output  5  Register file write address.
REQ-009 Write_Enable  output  1  Register file write strobe.
REQ-010 Mux_ctrl  output  1  Write-back select: 1 = ALU result, 0 = Load_Data.
REQ-011 opcode  output  3  ALU operation code.
REQ-012 Load_Data  output  32  Immediate value presented as datapath Data_in.
REQ-013 Done  output  1  One-cycle pulse when an instruction retires.
REQ-014 Zero_Flag  output  1  Zero status latched from the last ALU instruction.
REQ-015 Retired  output  16  Count of retired instructions.

Function
REQ-016 Instr fields: [31] kind (0 = ALU, 1 = load immediate); [30:28] ALU op; [27:23] rd; [22:18] rs1; [17:13] rs2; [12:0] ignored for ALU instructions.
REQ-017 For a load, the immediate is Instr[22:0], zero-extended to 32 bits; the op, rs1 and rs2 fields are ignored.
REQ-018 The FSM SHALL have the states IDLE, READ and WRITE; reset state is IDLE.
REQ-019 Instr_Ready SHALL be 1 only in IDLE, and only when Reset=0.
REQ-020 Handshake: IDLE with Instr_Valid=1 captures Instr into an internal register on that edge.
REQ-021 The FSM then goes to READ for an ALU instruction and directly to WRITE for a load.
REQ-022 READ SHALL last exactly 1 cycle.
REQ-023 In READ, Read_Addr_1=rs1, Read_Addr_2=rs2, opcode=op and Write_Enable=0; the next state is WRITE.
REQ-024 WRITE SHALL last exactly 1 cycle, with Write_Enable=1 and Write_Addr=rd.
REQ-025 In WRITE for an ALU instruction, Mux_ctrl=1, and read addresses and opcode are held at their READ values.
REQ-026 In WRITE for a load, Mux_ctrl=0 and Load_Data=immediate.
REQ-027 Done=1 during WRITE; the next state is IDLE.
REQ-028 All outputs SHALL be registered or decoded from registered state only, with no combinational path from Instr or Instr_Valid to any output.
REQ-029 Latency, ALU instruction: handshake at edge N; READ in cycle N+1; WRITE in cycle N+2; Instr_Ready=1 again in cycle N+3.
REQ-030 Latency, load: handshake at edge N; WRITE in cycle N+1; Instr_Ready=1 again in cycle N+2.
REQ-031 Zero_Flag SHALL load Zero at the edge ending WRITE of an ALU instruction; a load leaves it unchanged.
REQ-032 Retired SHALL increment by 1 at the edge ending each WRITE and wrap from 16'hFFFF to 0.
REQ-033 Outside WRITE: Write_Enable=0, Done=0, Mux_ctrl=1, and Load_Data holds its last value.
REQ-034 In IDLE with Instr_Valid=0, the FSM stays in IDLE and all outputs hold.
REQ-035 Instr changes while not in IDLE SHALL be ignored; only the captured copy is used.
REQ-036 rd=0 is an ordinary register; there is no special-casing.

Reset
REQ-037 Reset=1 at any edge forces IDLE, regardless of state, including mid-instruction.
REQ-038 Reset clears Zero_Flag=0, Retired=0, Done=0, Write_Enable=0, opcode=0, all addresses=0, Load_Data=0 and Mux_ctrl=1.
REQ-039 Reset asserted in READ SHALL suppress the pending WRITE: no Write_Enable pulse follows and Retired does not increment.
REQ-040 Instr_Valid=1 together with Reset=1 SHALL NOT capture the instruction.
REQ-041 The first handshake can occur on the first edge with Reset=0.

Verification
REQ-042 Load, then ALU add:
- Stimulus: load rd=3, imm=0x00012345; then ALU op=0, rd=5, rs1=3, rs2=3.
- Response: load WRITE shows Write_Addr=3, Mux_ctrl=0, Load_Data=0x00012345.
- Response: add READ shows Read_Addr_1=3, Read_Addr_2=3, opcode=0; add WRITE shows Write_Addr=5, Mux_ctrl=1.
- Response: Retired=2.
REQ-043 Zero flag:
- Stimulus: ALU subtract op=1 with rs1=rs2 and Zero=1 in WRITE; then a load.
- Response: Zero_Flag=1 after the subtract and still 1 after the load.
REQ-044 Back-to-back:
- Stimulus: Instr_Valid held at 1 with 4 ALU instructions queued.
- Response: handshakes 3 cycles apart; Done pulses at cycles 2, 5, 8 and 11 after the first handshake.
REQ-045 Reset mid-instruction:
- Stimulus: Reset=1 during READ.
- Response: no Write_Enable pulse; next cycle is IDLE with Instr_Ready=1; Retired=0.
REQ-046 Counter wrap:
- Stimulus: Retired preloaded to 0xFFFF by issuing 65535 loads, then one more load.
- Response: Retired=0x0000.
REQ-047 Instruction hold:
- Stimulus: Instr changed during READ.
- Response: WRITE still uses the originally captured rd and opcode.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Instruction controller: captures one instruction per handshake and
// sequences register-file read/write-back through IDLE, READ and WRITE.
module datapath_ctrl (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Instr_Valid,
    output logic        Instr_Ready,
    input  logic        Zero,
    output logic [4:0]  Read_Addr_1,
    output logic [4:0]  Read_Addr_2,
    output logic [4:0]  Write_Addr,
    output logic        Write_Enable,
    output logic        Mux_ctrl,
    output logic [2:0]  opcode,
    output logic [31:0] Load_Data,
    output logic        Done,
    output logic        Zero_Flag,
    output logic [15:0] Retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        r_is_load;
    logic [4:0]  r_ra1;
    logic [4:0]  r_ra2;
    logic [4:0]  r_wa;
    logic [2:0]  r_op;
    logic [31:0] r_load;
    logic        r_zero;
    logic [15:0] r_retired;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (Instr_Valid) begin
                    w_accept = 1'b1;
                    w_next   = Instr[31] ? WRITE : READ;
                end
            end
            READ:    w_next = WRITE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Fields are latched at the handshake, so later Instr changes are ignored
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_is_load <= 1'b0;
            r_ra1     <= 5'd0;
            r_ra2     <= 5'd0;
            r_wa      <= 5'd0;
            r_op      <= 3'd0;
            r_load    <= 32'd0;
            r_zero    <= 1'b0;
            r_retired <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_load <= Instr[31];
                r_wa      <= Instr[27:23];
                if (Instr[31]) begin
                    r_load <= {9'd0, Instr[22:0]};
                end else begin
                    r_op  <= Instr[30:28];
                    r_ra1 <= Instr[22:18];
                    r_ra2 <= Instr[17:13];
                end
            end
            if (r_state == WRITE) begin
                r_retired <= r_retired + 16'd1;
                if (!r_is_load) begin
                    r_zero <= Zero;
                end
            end
        end
    end

    assign Instr_Ready  = (r_state == IDLE) && !Reset;
    assign Write_Enable = (r_state == WRITE);
    assign Done         = (r_state == WRITE);
    assign Mux_ctrl     = !((r_state == WRITE) && r_is_load);
    assign Read_Addr_1  = r_ra1;
    assign Read_Addr_2  = r_ra2;
    assign Write_Addr   = r_wa;
    assign opcode       = r_op;
    assign Load_Data    = r_load;
    assign Zero_Flag    = r_zero;
    assign Retired      = r_retired;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: directed instructions queue their
// expected write-back; a negedge monitor checks each Done pulse.
module tb_datapath_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = 32'd0;
    logic        Instr_Valid = 1'b0;
    logic        Instr_Ready;
    logic        Zero = 1'b0;
    logic [4:0]  Read_Addr_1;
    logic [4:0]  Read_Addr_2;
    logic [4:0]  Write_Addr;
    logic        Write_Enable;
    logic        Mux_ctrl;
    logic [2:0]  opcode;
    logic [31:0] Load_Data;
    logic        Done;
    logic        Zero_Flag;
    logic [15:0] Retired;

    datapath_ctrl dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Instr        (Instr),
        .Instr_Valid  (Instr_Valid),
        .Instr_Ready  (Instr_Ready),
        .Zero         (Zero),
        .Read_Addr_1  (Read_Addr_1),
        .Read_Addr_2  (Read_Addr_2),
        .Write_Addr   (Write_Addr),
        .Write_Enable (Write_Enable),
        .Mux_ctrl     (Mux_ctrl),
        .opcode       (opcode),
        .Load_Data    (Load_Data),
        .Done         (Done),
        .Zero_Flag    (Zero_Flag),
        .Retired      (Retired)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        load;
        logic [4:0]  wa;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [2:0]  op;
        logic [31:0] ld;
        logic        zf;
        logic [15:0] ret;
        int          dc;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc   = 0;

    logic [4:0]  m_ra1 = 5'd0;
    logic [4:0]  m_ra2 = 5'd0;
    logic [2:0]  m_op  = 3'd0;
    logic [31:0] m_ld  = 32'd0;
    logic        m_zf  = 1'b0;
    logic [15:0] m_ret = 16'd0;

    logic        pend = 1'b0;
    logic        pend_zf;
    logic [15:0] pend_ret;

    always @(posedge Clock) ncyc <= ncyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] alu(logic [2:0] op, logic [4:0] rd,
                                        logic [4:0] rs1, logic [4:0] rs2);
        return {1'b0, op, rd, rs1, rs2, 13'h1abc};
    endfunction

    function automatic logic [31:0] ldi(logic [4:0] rd, logic [22:0] imm);
        return {1'b1, 3'd0, rd, imm};
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic issue(input logic [31:0] ins, output int hs);
        exp_t e;
        bit   ok = 0;
        hs = -1;
        for (int t = 0; t < 10 && !ok; t++) begin
            Instr       = ins;
            Instr_Valid = 1'b1;
            #1;
            if (Instr_Ready) begin
                ok = 1;
                hs = ncyc;
                if (ins[31]) begin
                    m_ld = {9'd0, ins[22:0]};
                end else begin
                    m_ra1 = ins[22:18];
                    m_ra2 = ins[17:13];
                    m_op  = ins[30:28];
                    m_zf  = Zero;
                end
                m_ret  = m_ret + 16'd1;
                e.load = ins[31];
                e.wa   = ins[27:23];
                e.ra1  = m_ra1;
                e.ra2  = m_ra2;
                e.op   = m_op;
                e.ld   = m_ld;
                e.zf   = m_zf;
                e.ret  = m_ret;
                e.dc   = ncyc + (ins[31] ? 1 : 2);
                sb.push_back(e);
            end
            @(negedge Clock);
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_timeout: got no Instr_Ready, expected 1");
        end
    endtask

    task automatic idle(input int n);
        Instr_Valid = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (pend) begin
            pend = 1'b0;
            chk("zero_flag", 32'(Zero_Flag), 32'(pend_zf));
            chk("retired", 32'(Retired), 32'(pend_ret));
        end
        if (Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(ncyc), 32'(e.dc));
                chk("write_enable", 32'(Write_Enable), 32'd1);
                chk("write_addr", 32'(Write_Addr), 32'(e.wa));
                chk("mux_ctrl", 32'(Mux_ctrl), 32'(!e.load));
                chk("read_addr_1", 32'(Read_Addr_1), 32'(e.ra1));
                chk("read_addr_2", 32'(Read_Addr_2), 32'(e.ra2));
                chk("opcode", 32'(opcode), 32'(e.op));
                chk("load_data", Load_Data, e.ld);
                pend     = 1'b1;
                pend_zf  = e.zf;
                pend_ret = e.ret;
            end
        end
    end

    initial begin
        int hs;
        int hsv[4];

        repeat (3) @(negedge Clock);
        chk("rst_ready", 32'(Instr_Ready), 32'd0);
        chk("rst_we", 32'(Write_Enable), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_mux", 32'(Mux_ctrl), 32'd1);
        chk("rst_load_data", Load_Data, 32'd0);
        chk("rst_ra1", 32'(Read_Addr_1), 32'd0);
        chk("rst_ra2", 32'(Read_Addr_2), 32'd0);
        chk("rst_wa", 32'(Write_Addr), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_zero_flag", 32'(Zero_Flag), 32'd0);
        chk("rst_retired", 32'(Retired), 32'd0);

        // Load then add, first handshake on the first edge out of reset
        Reset = 1'b0;
        issue(ldi(5'd3, 23'h012345), hs);
        chk("first_hs_cycle", 32'(hs), 32'd3);
        issue(alu(3'd0, 5'd5, 5'd3, 5'd3), hs);
        chk("read_ra1", 32'(Read_Addr_1), 32'd3);
        chk("read_ra2", 32'(Read_Addr_2), 32'd3);
        chk("read_opcode", 32'(opcode), 32'd0);
        chk("read_we", 32'(Write_Enable), 32'd0);
        chk("read_done", 32'(Done), 32'd0);
        chk("read_mux", 32'(Mux_ctrl), 32'd1);
        idle(3);
        chk("retired_two", 32'(Retired), 32'd2);

        // Zero flag survives a load; largest immediate zero-extends
        Zero = 1'b1;
        issue(alu(3'd1, 5'd7, 5'd4, 5'd4), hs);
        idle(3);
        Zero = 1'b0;
        issue(ldi(5'd1, 23'h7fffff), hs);
        idle(3);
        chk("zf_after_load", 32'(Zero_Flag), 32'd1);
        issue(alu(3'd2, 5'd0, 5'd1, 5'd2), hs);
        idle(3);
        chk("zf_cleared", 32'(Zero_Flag), 32'd0);

        // Back-to-back: Instr changes during READ of each instruction
        issue(alu(3'd3, 5'd10, 5'd11, 5'd12), hsv[0]);
        issue(alu(3'd4, 5'd13, 5'd14, 5'd15), hsv[1]);
        issue(alu(3'd5, 5'd16, 5'd17, 5'd18), hsv[2]);
        issue(alu(3'd6, 5'd31, 5'd19, 5'd20), hsv[3]);
        Instr = alu(3'd7, 5'd2, 5'd2, 5'd2);
        idle(4);
        for (int i = 1; i < 4; i++) begin
            chk("b2b_hs_gap", 32'(hsv[i] - hsv[i-1]), 32'd3);
        end

        // Reset during READ suppresses the write
        Instr       = alu(3'd1, 5'd9, 5'd8, 5'd7);
        Instr_Valid = 1'b1;
        @(negedge Clock);
        Instr_Valid = 1'b0;
        Reset       = 1'b1;
        @(negedge Clock);
        chk("rmid_we", 32'(Write_Enable), 32'd0);
        chk("rmid_done", 32'(Done), 32'd0);
        chk("rmid_wa", 32'(Write_Addr), 32'd0);
        Reset = 1'b0;
        #1;
        chk("rmid_ready", 32'(Instr_Ready), 32'd1);
        chk("rmid_retired", 32'(Retired), 32'd0);
        @(negedge Clock);
        chk("rmid_we_after", 32'(Write_Enable), 32'd0);
        chk("rmid_done_after", 32'(Done), 32'd0);
        m_ra1 = 5'd0;
        m_ra2 = 5'd0;
        m_op  = 3'd0;
        m_ld  = 32'd0;
        m_zf  = 1'b0;
        m_ret = 16'd0;

        // Valid together with Reset is not captured
        Reset       = 1'b1;
        Instr       = ldi(5'd9, 23'h000055);
        Instr_Valid = 1'b1;
        @(negedge Clock);
        chk("rv_ready", 32'(Instr_Ready), 32'd0);
        Instr_Valid = 1'b0;
        Reset       = 1'b0;
        @(negedge Clock);
        chk("rv_done", 32'(Done), 32'd0);
        chk("rv_load_data", Load_Data, 32'd0);
        chk("rv_wa", 32'(Write_Addr), 32'd0);
        chk("rv_retired", 32'(Retired), 32'd0);

        // Retired wraps from FFFF to 0
        force dut.r_retired = 16'hfffe;
        @(negedge Clock);
        release dut.r_retired;
        m_ret = 16'hfffe;
        issue(ldi(5'd4, 23'h000001), hs);
        issue(ldi(5'd6, 23'h000002), hs);
        idle(3);
        chk("retired_wrap", 32'(Retired), 32'd0);

        for (int t = 0; t < 20 && (sb.size() != 0 || pend); t++) begin
            @(negedge Clock);
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
